click_cell_encoder: RTL and testbench

- Converts the player's pointer position and debounced push-buttons into the one-hot cell-click, random-click, erase and restart inputs consumed by the tic-tac-toe game state machine.
- This is the producer side of the `cuadro`/`randomClick` interface.
- Sits between the pointer/button front end (mouse or board switches) and the game FSM.
- Holds the selected cell for as long as the button is held, because the game FSM advances on click release.

---
 rtl/click_cell_encoder_pkg.sv | 23 ++
 rtl/click_cell_encoder_button_debouncer.sv | 50 +++++
 rtl/click_cell_encoder.sv | 125 ++++++++++++
 tb/tb_click_cell_encoder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/click_cell_encoder_pkg.sv
// Shared grid constants, click FSM state encoding and the (row,col) to one-hot
// cell mapping used by the click/cell encoder.
package click_cell_encoder_pkg;

  localparam int GRID_ROWS = 3;
  localparam int GRID_COLS = 3;
  localparam int NUM_CELLS = GRID_ROWS * GRID_COLS;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD     = 2'd1,
    ST_HOLD_OUT = 2'd2
  } click_state_t;

  // Bit index is row*3+col, row 0 at the top of the grid.
  function automatic logic [NUM_CELLS-1:0] cell_onehot(input logic [1:0] row,
                                                       input logic [1:0] col);
    logic [3:0] idx;
    idx = ({2'b00, row} * 4'd3) + {2'b00, col};
    return 9'd1 << idx;
  endfunction

endpackage

// File: rtl/click_cell_encoder_button_debouncer.sv
// Raw button conditioning: 2-FF synchronizer, stability counter, debounced
// level and a registered one-cycle pulse on each accepted rising level.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_r;
  logic          sync2_r;
  logic [CW-1:0] cnt_r;

  // Two-stage synchronizer for the asynchronous raw button.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

  // The cycle the counter would reach DEBOUNCE_CYCLES is the accept cycle:
  // the level flips there, so the press pulse leaves together with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else if (sync2_r == level) begin
      cnt_r <= '0;
      rise  <= 1'b0;
    end else if (cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt_r <= '0;
      level <= sync2_r;
      rise  <= sync2_r;
    end else begin
      cnt_r <= cnt_r + CW'(1);
      rise  <= 1'b0;
    end
  end

endmodule

// File: rtl/click_cell_encoder.sv
// Pointer/button to tic-tac-toe click encoder (cuadro/randomClick producer).
// Optional feature macro: CELL_HOVER_EN enables the registered hover one-hot.
module click_cell_encoder
  import click_cell_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int GRID_X0         = 160,
  parameter int GRID_Y0         = 80,
  parameter int CELL_W          = 100,
  parameter int CELL_H          = 100
) (
  input  logic       clk_100MHz,
  input  logic       rst_n,
  input  logic [9:0] ptr_x,
  input  logic [9:0] ptr_y,
  input  logic       btn_click,
  input  logic       btn_erase,
  input  logic       btn_restart,
  output logic [8:0] cuadro,
  output logic       randomClick,
  output logic       erase,
  output logic       restart,
  output logic [8:0] hover
);

  localparam logic [10:0] X0 = 11'(GRID_X0);
  localparam logic [10:0] X1 = 11'(GRID_X0 + CELL_W);
  localparam logic [10:0] X2 = 11'(GRID_X0 + 2 * CELL_W);
  localparam logic [10:0] X3 = 11'(GRID_X0 + 3 * CELL_W);
  localparam logic [10:0] Y0 = 11'(GRID_Y0);
  localparam logic [10:0] Y1 = 11'(GRID_Y0 + CELL_H);
  localparam logic [10:0] Y2 = 11'(GRID_Y0 + 2 * CELL_H);
  localparam logic [10:0] Y3 = 11'(GRID_Y0 + 3 * CELL_H);

  logic         click_level_s, click_rise_s;
  logic         erase_level_s, erase_rise_s;
  logic         restart_level_s, restart_rise_s;
  logic [10:0]  px_s, py_s;
  logic         in_s;
  logic [1:0]   row_s, col_s;
  click_state_t state_r;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_click (
    .clk(clk_100MHz), .rst_n(rst_n), .btn(btn_click),
    .level(click_level_s), .rise(click_rise_s));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_erase (
    .clk(clk_100MHz), .rst_n(rst_n), .btn(btn_erase),
    .level(erase_level_s), .rise(erase_rise_s));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_restart (
    .clk(clk_100MHz), .rst_n(rst_n), .btn(btn_restart),
    .level(restart_level_s), .rise(restart_rise_s));

  assign px_s = {1'b0, ptr_x};
  assign py_s = {1'b0, ptr_y};
  assign in_s = (px_s >= X0) && (px_s < X3) && (py_s >= Y0) && (py_s < Y3);

  // Comparator-only hit test; 11-bit constants keep grid edges from wrapping.
  always_comb begin
    col_s = 2'd0;
    row_s = 2'd0;
    if (px_s < X1)      col_s = 2'd0;
    else if (px_s < X2) col_s = 2'd1;
    else                col_s = 2'd2;
    if (py_s < Y1)      row_s = 2'd0;
    else if (py_s < Y2) row_s = 2'd1;
    else                row_s = 2'd2;
  end

  // Click FSM with registered outputs; cell is latched on the accepted press
  // and held until the debounced button drops, since the game acts on release.
  always_ff @(posedge clk_100MHz) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cuadro      <= 9'd0;
      randomClick <= 1'b0;
      erase       <= 1'b0;
      restart     <= 1'b0;
    end else begin
      randomClick <= 1'b0;
      erase       <= erase_rise_s;
      restart     <= restart_rise_s;
      case (state_r)
        ST_IDLE: begin
          if (click_rise_s) begin
            randomClick <= 1'b1;
            if (in_s) begin
              cuadro  <= cell_onehot(row_s, col_s);
              state_r <= ST_HOLD;
            end else begin
              cuadro  <= 9'd0;
              state_r <= ST_HOLD_OUT;
            end
          end else begin
            cuadro <= 9'd0;
          end
        end
        ST_HOLD: begin
          if (!click_level_s) begin
            cuadro  <= 9'd0;
            state_r <= ST_IDLE;
          end
        end
        ST_HOLD_OUT: begin
          cuadro <= 9'd0;
          if (!click_level_s) state_r <= ST_IDLE;
        end
        default: begin
          cuadro  <= 9'd0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CELL_HOVER_EN
  // Highlight tracks the pointer every cycle, independent of the buttons.
  always_ff @(posedge clk_100MHz) begin
    if (!rst_n) hover <= 9'd0;
    else        hover <= in_s ? cell_onehot(row_s, col_s) : 9'd0;
  end
`else
  assign hover = 9'd0;
`endif

endmodule

// File: tb/tb_click_cell_encoder.sv
// Directed + randomized bench for click_cell_encoder with an arithmetic
// (division-based) reference for the grid and fixed-latency button timing.
module tb_click_cell_encoder;

  localparam int D   = 4;
  localparam int GX0 = 100;
  localparam int GY0 = 50;
  localparam int CW  = 100;
  localparam int CH  = 100;
  localparam int LAT = D + 3;

  logic       clk_100MHz;
  logic       rst_n;
  logic [9:0] ptr_x, ptr_y;
  logic       btn_click, btn_erase, btn_restart;
  logic [8:0] cuadro, hover;
  logic       randomClick, erase, restart;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  click_cell_encoder #(
    .DEBOUNCE_CYCLES(D), .GRID_X0(GX0), .GRID_Y0(GY0), .CELL_W(CW), .CELL_H(CH)
  ) dut (
    .clk_100MHz(clk_100MHz), .rst_n(rst_n), .ptr_x(ptr_x), .ptr_y(ptr_y),
    .btn_click(btn_click), .btn_erase(btn_erase), .btn_restart(btn_restart),
    .cuadro(cuadro), .randomClick(randomClick), .erase(erase),
    .restart(restart), .hover(hover)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  // Reference: which cell the pointer is in, by plain division.
  function automatic logic [8:0] ref_cell(input int x, input int y);
    int r, c;
    if (x < GX0 || x >= GX0 + 3 * CW || y < GY0 || y >= GY0 + 3 * CH) return 9'd0;
    c = (x - GX0) / CW;
    r = (y - GY0) / CH;
    return 9'd1 << (r * 3 + c);
  endfunction

  function automatic logic [8:0] ref_hover(input int x, input int y);
`ifdef CELL_HOVER_EN
    return ref_cell(x, y);
`else
    return 9'd0 & ref_cell(x, y);
`endif
  endfunction

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_100MHz);
    #1;
  endtask

  // Press click at (x,y) and verify the pulse/cell appear exactly at LAT.
  task automatic press_check(input string tag, input int x, input int y);
    logic [8:0] exp;
    exp = ref_cell(x, y);
    ptr_x = 10'(x);
    ptr_y = 10'(y);
    btn_click = 1'b1;
    tick(LAT - 1);
    check({tag, "_early_rc"}, {8'd0, randomClick}, 9'd0);
    check({tag, "_early_cu"}, cuadro, 9'd0);
    check({tag, "_hover"}, hover, ref_hover(x, y));
    tick(1);
    check({tag, "_rc"}, {8'd0, randomClick}, 9'd1);
    check({tag, "_cu"}, cuadro, exp);
    tick(1);
    check({tag, "_rc_1cyc"}, {8'd0, randomClick}, 9'd0);
    check({tag, "_cu_hold"}, cuadro, exp);
  endtask

  task automatic release_check(input string tag, input logic [8:0] exp);
    btn_click = 1'b0;
    tick(LAT - 1);
    check({tag, "_rel_early"}, cuadro, exp);
    tick(1);
    check({tag, "_rel"}, cuadro, 9'd0);
    tick(2);
  endtask

  initial begin
    int x, y, run;
    logic v;
    rst_n = 1'b0;
    ptr_x = 10'd0; ptr_y = 10'd0;
    btn_click = 1'b0; btn_erase = 1'b0; btn_restart = 1'b0;
    tick(2);
    check("rst_cuadro", cuadro, 9'd0);
    check("rst_pulses", {6'd0, randomClick, erase, restart}, 9'd0);
    check("rst_hover", hover, 9'd0);
    rst_n = 1'b1;
    tick(2);

    // 1: centre cell
    press_check("t1", 250, 160);
    tick(12);
    check("t1_no_repeat", {8'd0, randomClick}, 9'd0);
    check("t1_still", cuadro, 9'b000010000);
    release_check("t1", 9'b000010000);

    // 2: regular bouncing never qualifies
    for (int i = 0; i < 30; i++) begin
      btn_click = ((i / 2) % 2 == 0);
      tick(1);
      if (randomClick !== 1'b0 || cuadro !== 9'd0)
        check("t2_bounce", {randomClick, cuadro[7:0]}, 9'd0);
    end
    btn_click = 1'b0;
    tick(LAT + 1);
    check("t2_level", {8'd0, dut.u_click.level}, 9'd0);
    check("t2_cuadro", cuadro, 9'd0);

    // random short runs (< D) also never qualify
    v = 1'b1;
    for (int i = 0; i < 12; i++) begin
      btn_click = v;
      run = $urandom_range(1, D - 1);
      for (int k = 0; k < run; k++) begin
        tick(1);
        if (randomClick !== 1'b0) check("rb_bounce", {8'd0, randomClick}, 9'd0);
      end
      v = ~v;
    end
    btn_click = 1'b0;
    tick(LAT + 1);
    check("rb_level", {8'd0, dut.u_click.level}, 9'd0);

    // 3: outside click and simultaneous erase/restart
    press_check("t3", 50, 40);
    release_check("t3", 9'd0);
    btn_erase = 1'b1; btn_restart = 1'b1;
    tick(LAT - 1);
    check("t3_er_early", {7'd0, erase, restart}, 9'd0);
    tick(1);
    check("t3_er", {7'd0, erase, restart}, 9'd3);
    tick(1);
    check("t3_er_1cyc", {7'd0, erase, restart}, 9'd0);
    btn_erase = 1'b0; btn_restart = 1'b0;
    tick(LAT + 1);
    check("t3_er_rel", {7'd0, erase, restart}, 9'd0);

    // 4: latched cell ignores pointer motion
    press_check("t4", 120, 60);
    ptr_x = 10'd390; ptr_y = 10'd340;
    tick(5);
    check("t4_frozen", cuadro, 9'b000000001);
    check("t4_hover", hover, ref_hover(390, 340));
    release_check("t4", 9'b000000001);

    // 5: grid edges
    press_check("b1", 399, 50);  release_check("b1", ref_cell(399, 50));
    press_check("b2", 400, 50);  release_check("b2", ref_cell(400, 50));
    press_check("b3", 100, 349); release_check("b3", ref_cell(100, 349));
    press_check("b4", 100, 350); release_check("b4", ref_cell(100, 350));
    check("b_model1", ref_cell(399, 50), 9'b000000100);
    check("b_model3", ref_cell(100, 349), 9'b001000000);

    // random pointer positions
    for (int i = 0; i < 8; i++) begin
      x = $urandom_range(0, 520);
      y = $urandom_range(0, 420);
      press_check("rnd", x, y);
      release_check("rnd", ref_cell(x, y));
    end

    // 6: reset mid-hold with the button still down
    press_check("t6", 250, 160);
    rst_n = 1'b0;
    tick(1);
    check("t6_rst_cu", cuadro, 9'd0);
    check("t6_rst_rc", {8'd0, randomClick}, 9'd0);
    rst_n = 1'b1;
    tick(LAT - 1);
    check("t6_early", cuadro, 9'd0);
    tick(1);
    check("t6_rc", {8'd0, randomClick}, 9'd1);
    check("t6_cu", cuadro, 9'b000010000);
    release_check("t6", 9'b000010000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
